// File: rtl/inserter_ctrl_if.sv
// Entry stream from the inserter sequencer to the anonymizer table loader.
// The master presents an entry and holds it until out_ready is seen with out_valid.
interface inserter_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned IP_WIDTH   = 32,
   parameter int unsigned URL_WIDTH  = 512
);
   logic                  out_valid;
   logic                  out_ready;
   logic [IP_WIDTH-1:0]   out_ip_addr;
   logic [URL_WIDTH-1:0]  out_url;
   logic [ADDR_WIDTH-1:0] out_index;

   modport master (
      output out_valid, out_ip_addr, out_url, out_index,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_ip_addr, out_url, out_index,
      output out_ready
   );
endinterface

// File: rtl/inserter_ctrl.sv
// Walks the inserter ROM pair from address 0 to count-1.
// Each ROM word pair goes out as one entry on the valid/ready stream.
module inserter_ctrl #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned IP_WIDTH   = 32,
   parameter int unsigned URL_WIDTH  = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   count,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rom_address,
   input  logic [IP_WIDTH-1:0]   rom_ip_addr_data,
   input  logic [URL_WIDTH-1:0]  rom_url_data,
   inserter_ctrl_if.master       out_if
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_SEND  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [ADDR_WIDTH-1:0] w_idx_next;
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH:0]   w_count_next;
   logic                  w_capture;
   logic                  w_last;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_valid;
   logic [IP_WIDTH-1:0]   r_ip;
   logic [URL_WIDTH-1:0]  r_url;
   logic [ADDR_WIDTH-1:0] r_index;

   // idx never reaches count, so comparing against count-1 needs the extra bit
   assign w_last = ({1'b0, r_idx} == (r_count - (ADDR_WIDTH + 1)'(1)));

   // Next-state and datapath control
   always_comb begin
      w_next       = r_state;
      w_idx_next   = r_idx;
      w_count_next = r_count;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (count == '0) begin
                  w_next = S_DONE;
               end else begin
                  w_count_next = count;
                  w_idx_next   = '0;
                  w_next       = S_FETCH;
               end
            end
         end
         S_FETCH: w_next = S_LOAD;
         S_LOAD: begin
            w_capture = 1'b1;
            w_next    = S_SEND;
         end
         S_SEND: begin
            if (out_if.out_ready) begin
               if (w_last) begin
                  w_next = S_DONE;
               end else begin
                  w_idx_next = r_idx + ADDR_WIDTH'(1);
                  w_next     = S_FETCH;
               end
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      // Abort wins over a same-cycle handshake and suppresses the done pulse
      if (abort && (r_state != S_IDLE)) begin
         w_next     = S_IDLE;
         w_idx_next = r_idx;
         w_capture  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
         r_ip    <= '0;
         r_url   <= '0;
         r_index <= '0;
      end else begin
         r_state <= w_next;
         r_idx   <= w_idx_next;
         r_count <= w_count_next;
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (w_next == S_DONE);
         r_valid <= (w_next == S_SEND);
         if (w_capture) begin
            r_ip    <= rom_ip_addr_data;
            r_url   <= rom_url_data;
            r_index <= r_idx;
         end
      end
   end

   assign busy               = r_busy;
   assign done               = r_done;
   assign rom_address        = r_idx;
   assign out_if.out_valid   = r_valid;
   assign out_if.out_ip_addr = r_ip;
   assign out_if.out_url     = r_url;
   assign out_if.out_index   = r_index;

endmodule

// File: tb/tb_inserter_ctrl.sv
// Directed bench for inserter_ctrl with a behavioural one-cycle ROM pair.
module tb_inserter_ctrl;
   localparam int unsigned AW = 12;
   localparam int unsigned IW = 32;
   localparam int unsigned UW = 512;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW:0]   count = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] rom_address;
   logic [IW-1:0] rom_ip;
   logic [UW-1:0] rom_url;
   int            n_checks = 0;
   int            n_fail = 0;

   inserter_ctrl_if #(.ADDR_WIDTH(AW), .IP_WIDTH(IW), .URL_WIDTH(UW)) s_if ();

   inserter_ctrl #(.ADDR_WIDTH(AW), .IP_WIDTH(IW), .URL_WIDTH(UW)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .count            (count),
      .abort            (abort),
      .busy             (busy),
      .done             (done),
      .rom_address      (rom_address),
      .rom_ip_addr_data (rom_ip),
      .rom_url_data     (rom_url),
      .out_if           (s_if)
   );

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] ip_of(input logic [AW-1:0] a);
      return {20'hC0A80, a};
   endfunction

   function automatic logic [UW-1:0] url_of(input logic [AW-1:0] a);
      logic [31:0] w;
      w = 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
      return {a, {15{w}}, 20'hABCDE};
   endfunction

   always @(posedge clk) begin
      rom_ip  <= ip_of(rom_address);
      rom_url <= url_of(rom_address);
   end

   task automatic do_start(input int n);
      @(negedge clk);
      start = 1'b1;
      count = 13'(n);
   endtask

   // Unstalled run of n entries; cycle k is observed at the k-th negedge after start
   task automatic run_plain(input string tag, input int n);
      logic          ev;
      logic [AW-1:0] ei;
      do_start(n);
      for (int k = 1; k <= 3 * n + 3; k++) begin
         @(negedge clk);
         start = 1'b0;
         s_if.out_ready = 1'b1;
         ev = (k % 3 == 0) && (k <= 3 * n);
         n_checks++;
         if (s_if.out_valid !== ev) begin
            n_fail++; $display("FAIL %s_valid k=%0d got %b exp %b", tag, k, s_if.out_valid, ev);
         end
         n_checks++;
         if (done !== (k == 3 * n + 1)) begin
            n_fail++; $display("FAIL %s_done k=%0d got %b exp %b", tag, k, done, (k == 3 * n + 1));
         end
         n_checks++;
         if (busy !== (k <= 3 * n + 1)) begin
            n_fail++; $display("FAIL %s_busy k=%0d got %b exp %b", tag, k, busy, (k <= 3 * n + 1));
         end
         if (k == 1) begin
            n_checks++;
            if (rom_address !== '0) begin
               n_fail++; $display("FAIL %s_fetch_addr got %0d exp 0", tag, rom_address);
            end
         end
         if (ev) begin
            ei = AW'(k / 3 - 1);
            n_checks++;
            if (s_if.out_index !== ei || s_if.out_ip_addr !== ip_of(ei) || s_if.out_url !== url_of(ei)) begin
               n_fail++;
               $display("FAIL %s_entry k=%0d got idx %0d ip %h exp idx %0d ip %h", tag, k,
                        s_if.out_index, s_if.out_ip_addr, ei, ip_of(ei));
            end
         end
      end
   endtask

   task automatic test_reset();
      s_if.out_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || s_if.out_valid !== 1'b0 || rom_address !== '0 ||
          s_if.out_index !== '0 || s_if.out_ip_addr !== '0 || s_if.out_url !== '0) begin
         n_fail++;
         $display("FAIL reset_values got busy %b done %b valid %b addr %0d idx %0d ip %h exp all 0",
                  busy, done, s_if.out_valid, rom_address, s_if.out_index, s_if.out_ip_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_zero_count();
      do_start(0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
         n_checks++;
         if (done !== (k == 1)) begin
            n_fail++; $display("FAIL zero_done k=%0d got %b exp %b", k, done, (k == 1));
         end
         n_checks++;
         if (s_if.out_valid !== 1'b0 || rom_address !== '0) begin
            n_fail++; $display("FAIL zero_quiet k=%0d got valid %b addr %0d exp 0 0", k, s_if.out_valid, rom_address);
         end
         n_checks++;
         if (busy !== (k == 1)) begin
            n_fail++; $display("FAIL zero_busy k=%0d got %b exp %b", k, busy, (k == 1));
         end
      end
   endtask

   task automatic test_basic();
      run_plain("basic", 4);
   endtask

   task automatic test_backpressure();
      logic          ev;
      logic [AW-1:0] ei;
      do_start(3);
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         start = 1'b0;
         s_if.out_ready = !(k >= 6 && k <= 10);
         ev = (k == 3) || (k >= 6 && k <= 11) || (k == 14);
         ei = (k == 3) ? AW'(0) : (k == 14) ? AW'(2) : AW'(1);
         n_checks++;
         if (s_if.out_valid !== ev) begin
            n_fail++; $display("FAIL bp_valid k=%0d got %b exp %b", k, s_if.out_valid, ev);
         end
         n_checks++;
         if (done !== (k == 15)) begin
            n_fail++; $display("FAIL bp_done k=%0d got %b exp %b", k, done, (k == 15));
         end
         if (ev) begin
            n_checks++;
            if (s_if.out_index !== ei || s_if.out_ip_addr !== ip_of(ei) || s_if.out_url !== url_of(ei)) begin
               n_fail++; $display("FAIL bp_entry k=%0d got idx %0d ip %h exp idx %0d ip %h", k,
                                  s_if.out_index, s_if.out_ip_addr, ei, ip_of(ei));
            end
         end
      end
      s_if.out_ready = 1'b1;
   endtask

   task automatic test_abort();
      do_start(4);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         start = 1'b0;
         s_if.out_ready = 1'b1;
      end
      n_checks++;
      if (s_if.out_valid !== 1'b1 || s_if.out_index !== AW'(2)) begin
         n_fail++; $display("FAIL abort_pre got valid %b idx %0d exp 1 2", s_if.out_valid, s_if.out_index);
      end
      abort = 1'b1;
      for (int k = 10; k <= 14; k++) begin
         @(negedge clk);
         abort = 1'b0;
         n_checks++;
         if (busy !== 1'b0 || s_if.out_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle k=%0d got busy %b valid %b done %b exp 0 0 0",
                               k, busy, s_if.out_valid, done);
         end
      end
      n_checks++;
      if (rom_address !== AW'(2)) begin
         n_fail++; $display("FAIL abort_no_handshake got addr %0d exp 2", rom_address);
      end
      run_plain("abort_restart", 2);
   endtask

   task automatic test_full_range();
      int  hs = 0;
      int  ndone = 0;
      bit  seen = 1'b0;
      logic rdy;
      do_start(4096);
      for (int c = 0; c < 40000 && !seen; c++) begin
         @(negedge clk);
         start = 1'b0;
         rdy = ($urandom_range(0, 3) != 0);
         s_if.out_ready = rdy;
         if (done) begin
            seen = 1'b1;
            ndone++;
         end else if (s_if.out_valid && rdy) begin
            if (s_if.out_index !== AW'(hs)) begin
               n_checks++; n_fail++;
               $display("FAIL full_index got %0d exp %0d", s_if.out_index, hs);
            end
            hs++;
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL full_timeout got no done exp done within budget");
      end
      n_checks++;
      if (hs != 4096) begin
         n_fail++; $display("FAIL full_handshakes got %0d exp 4096", hs);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      n_checks++;
      if (ndone != 1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL full_done_pulse got %0d pulses busy %b exp 1 0", ndone, busy);
      end
      n_checks++;
      if (rom_address !== AW'(4095)) begin
         n_fail++; $display("FAIL full_no_wrap got addr %0d exp 4095", rom_address);
      end
      s_if.out_ready = 1'b1;
   endtask

   task automatic test_reset_mid_run();
      do_start(4);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         start = 1'b0;
         s_if.out_ready = 1'b1;
      end
      n_checks++;
      if (rom_address !== AW'(2) || busy !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_pre got addr %0d busy %b exp 2 1", rom_address, busy);
      end
      #1 rst = 1'b1;
      #2;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || s_if.out_valid !== 1'b0 || rom_address !== '0 ||
          s_if.out_index !== '0 || s_if.out_ip_addr !== '0) begin
         n_fail++;
         $display("FAIL rstmid_async got busy %b done %b valid %b addr %0d idx %0d exp all 0",
                  busy, done, s_if.out_valid, rom_address, s_if.out_index);
      end
      @(negedge clk);
      rst = 1'b0;
      run_plain("rstmid_restart", 2);
   endtask

   initial begin
      s_if.out_ready = 1'b1;
      test_reset();
      test_zero_count();
      test_basic();
      test_backpressure();
      test_abort();
      test_full_range();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
